// File: rtl/t_chain_counter_pkg.sv
// t_chain_pkg: shared constants, direction type and load clamp helper for t_chain_counter
package t_chain_pkg;
  localparam int T_CHAIN_MAX_WIDTH = 16;
  typedef enum logic {DIR_DOWN = 1'b0, DIR_UP = 1'b1} dir_e;
  function automatic logic [T_CHAIN_MAX_WIDTH-1:0] clamp_load(input logic [T_CHAIN_MAX_WIDTH-1:0] val, input int mod);
    logic [31:0] v;
    v = {16'd0, val};
    return (v < 32'(mod)) ? val : T_CHAIN_MAX_WIDTH'(mod - 1);
  endfunction
endpackage

// File: rtl/t_chain_counter_t_cell.sv
// t_cell: single toggle flip-flop (clk, sync active-high rst, t -> q)
module t_cell (
  input  logic clk,
  input  logic rst,
  input  logic t,
  output logic q
);
  logic q_d, q_q;
  always_comb q_d = q_q ^ t;
  always_ff @(posedge clk)
    if (rst) q_q <= 1'b0;
    else     q_q <= q_d;
  assign q = q_q;
endmodule

// File: rtl/t_chain_counter.sv
// t_chain_counter: up/down modulo counter of WIDTH t_cells driven by t_vec = q ^ next; define T_CHAIN_COUNTER_SAT_EN to saturate instead of wrap
module t_chain_counter
  import t_chain_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int MOD   = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             wrap
);
  localparam logic [WIDTH-1:0] LAST = WIDTH'(MOD - 1);
  dir_e dir;
  logic [WIDTH-1:0] inc, dec, load_d, nxt, t_vec;
  logic wrap_d, wrap_q;
  assign dir = dir_e'(up);
  assign tc  = en & (((dir == DIR_UP) & (q == LAST)) | ((dir == DIR_DOWN) & (q == '0)));
  always_comb begin
    load_d = WIDTH'(clamp_load(T_CHAIN_MAX_WIDTH'(load_val), MOD));
`ifdef T_CHAIN_COUNTER_SAT_EN
    inc    = (q >= LAST) ? LAST : q + WIDTH'(1);
    dec    = (q > LAST) ? LAST : (q == '0) ? '0 : q - WIDTH'(1);
    wrap_d = 1'b0;
`else
    inc    = (q >= LAST) ? '0 : q + WIDTH'(1);
    dec    = ((q == '0) || (q > LAST)) ? LAST : q - WIDTH'(1);
    wrap_d = tc & ~load;
`endif
    nxt    = load ? load_d : en ? ((dir == DIR_UP) ? inc : dec) : q;
    t_vec  = q ^ nxt;
  end
  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    t_cell u_cell (.clk(clk), .rst(rst), .t(t_vec[i]), .q(q[i]));
  end
  always_ff @(posedge clk)
    if (rst) wrap_q <= 1'b0;
    else     wrap_q <= wrap_d;
  assign wrap = wrap_q;
endmodule

// File: tb/tb_t_chain_counter.sv
// tb_t_chain_counter: table-driven check of t_chain_counter (MOD=10) plus a MOD=16 full-toggle sequence
module tb_t_chain_counter;
  logic clk = 1'b0;
  logic rst = 1'b1, en = 1'b0, up = 1'b1, load = 1'b0;
  logic [3:0] load_val = 4'd0;
  logic [3:0] q, q16, prev;
  logic tc, wrap, tc16, wrap16;
  int n_vec = 0, n_bad = 0;
  always #5 clk = ~clk;
  t_chain_counter #(.WIDTH(4), .MOD(10)) dut (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(load_val),
    .q(q), .tc(tc), .wrap(wrap)
  );
  t_chain_counter #(.WIDTH(4), .MOD(16)) dut16 (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(load_val),
    .q(q16), .tc(tc16), .wrap(wrap16)
  );
  typedef struct {
    logic r, l, e, u;
    logic [3:0] lv, eq;
    logic etc, ew;
  } vec_t;
  vec_t tbl[$];
  function automatic void add(logic r, logic l, logic e, logic u, logic [3:0] lv, logic [3:0] eq, logic etc, logic ew);
    vec_t v;
    v.r = r; v.l = l; v.e = e; v.u = u; v.lv = lv; v.eq = eq; v.etc = etc; v.ew = ew;
    tbl.push_back(v);
  endfunction
  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  initial begin
    add(1, 0, 0, 1, 0, 0, 0, 0);
    add(1, 0, 0, 1, 0, 0, 0, 0);
`ifdef T_CHAIN_COUNTER_SAT_EN
    add(0, 1, 0, 1, 8, 8, 0, 0);
    for (int k = 0; k < 4; k++) add(0, 0, 1, 1, 0, 9, 1, 0);
    add(0, 1, 0, 0, 0, 0, 0, 0);
    add(0, 0, 1, 0, 0, 0, 1, 0);
    add(0, 0, 1, 0, 0, 0, 1, 0);
    add(0, 1, 1, 1, 13, 9, 1, 0);
    add(0, 1, 0, 1, 5, 5, 0, 0);
    add(1, 1, 1, 1, 3, 0, 0, 0);
`else
    for (int k = 1; k <= 12; k++) add(0, 0, 1, 1, 0, 4'(k % 10), (k % 10) == 9, k == 10);
    add(0, 1, 1, 0, 7, 7, 0, 0);
    for (int k = 1; k <= 9; k++) add(0, 0, 1, 0, 0, 4'((17 - k) % 10), ((17 - k) % 10) == 0, k == 8);
    add(0, 1, 1, 1, 13, 9, 1, 0);
    add(0, 1, 1, 1, 10, 9, 1, 0);
    add(0, 0, 1, 1, 0, 0, 0, 1);
    for (int k = 1; k <= 5; k++) add(0, 0, 1, 1, 0, 4'(k), 0, 0);
    add(1, 1, 1, 1, 3, 0, 0, 0);
    add(0, 1, 0, 1, 9, 9, 0, 0);
    add(1, 0, 1, 1, 0, 0, 0, 0);
    add(0, 1, 0, 1, 4, 4, 0, 0);
    for (int k = 0; k < 5; k++) add(0, 0, 0, k[0], 0, 4, 0, 0);
`endif
    for (int i = 0; i < tbl.size(); i++) begin
      rst = tbl[i].r; load = tbl[i].l; en = tbl[i].e; up = tbl[i].u; load_val = tbl[i].lv;
      tick();
      n_vec++;
      chk($sformatf("v%0d q", i), q, tbl[i].eq);
      chk($sformatf("v%0d tc", i), {3'b0, tc}, {3'b0, tbl[i].etc});
      chk($sformatf("v%0d wrap", i), {3'b0, wrap}, {3'b0, tbl[i].ew});
    end
    rst = 1'b0; load = 1'b1; en = 1'b0; up = 1'b1; load_val = 4'd15;
    tick();
    n_vec++;
    chk("m16 load q", q16, 4'd15);
    load = 1'b0; en = 1'b1;
    #1;
    n_vec++;
    chk("m16 tc", {3'b0, tc16}, 4'd1);
    prev = q16;
    tick();
    n_vec++;
`ifdef T_CHAIN_COUNTER_SAT_EN
    chk("m16 sat q", q16, 4'd15);
    chk("m16 sat toggles", q16 ^ prev, 4'h0);
    chk("m16 sat wrap", {3'b0, wrap16}, 4'd0);
    tick();
    n_vec++;
    chk("m16 sat hold q", q16, 4'd15);
    chk("m16 sat hold wrap", {3'b0, wrap16}, 4'd0);
`else
    chk("m16 wrap q", q16, 4'd0);
    chk("m16 toggles", q16 ^ prev, 4'hF);
    chk("m16 wrap", {3'b0, wrap16}, 4'd1);
    tick();
    n_vec++;
    chk("m16 next q", q16, 4'd1);
    chk("m16 wrap drop", {3'b0, wrap16}, 4'd0);
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/t_chain_counter.md
Name: t_chain_counter

Overview:
- Synchronous up/down modulo counter built from a chain of T-flip-flop cells.
- Each cell's toggle input is derived from the state of the cells below it, so it consumes toggle-cell outputs and feeds them back.
- Downstream stage of the single T flip-flop: replicates it WIDTH times and drives every T input.
- Used as a divider/event counter by later sequential blocks.

Parameters:
- WIDTH, 4, number of T cells (counter bits); legal range 2..16.
- MOD, 10, count modulus; legal range 2..2^WIDTH; count range 0..MOD-1.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- en  input  1  count enable; one step per clk edge while high.
- up  input  1  direction: 1 = increment, 0 = decrement.
- load  input  1  synchronous parallel load.
- load_val  input  WIDTH  value loaded when load=1.
- q  output  WIDTH  registered count (the T-cell outputs).
- tc  output  1  combinational terminal count: en & ((up & q==MOD-1) | (~up & q==0)).
- wrap  output  1  registered one-cycle pulse; high the cycle after a step crossed the terminal value.

Behaviour:
- One clock (clk); reset is synchronous and active-high (rst). All state changes on the rising edge of clk only.
- Reset values: q=0, wrap=0. tc follows q/en/up combinationally, so it is 0 after reset when up=1.
- Priority per edge: rst > load > en > hold.
- Load:
  - next = load_val when load_val < MOD, else MOD-1 (clamped).
  - wrap=0 on a load edge.
  - up and en are ignored on a load edge.
- Count, en=1:
  - up=1: next = (q==MOD-1) ? 0 : q+1.
  - up=0: next = (q==0) ? MOD-1 : q-1.
- Hold (en=0, no load): q unchanged, wrap=0.
- Toggle vector:
  - Count logic never writes q directly; it computes t_vec = q ^ next, and each cell i toggles when t_vec[i]=1.
  - For power-of-two MOD this reduces to the classic chain: bit i toggles when all lower bits are 1 (up) or all 0 (down).
  - For other MOD, the terminal-wrap term forces the extra toggles.
- wrap: registered 1 on the edge following any edge where tc=1 and a count step occurred (not load, not rst). It lasts exactly one cycle unless the next step wraps again (possible only for MOD=2 or MOD=1-step cases).
- Direction change mid-count takes effect on the same edge; no pipeline.
- Reset mid-count: q returns to 0 on that edge and any pending wrap is cleared.
- Latency: q reflects a step/load one cycle after the qualifying edge inputs are sampled.
- Out-of-range state (q >= MOD) is unreachable; the logic must still recover by treating it as terminal (next = 0 up, MOD-1 down).

Optional Feature:
- Macro T_CHAIN_COUNTER_SAT_EN.
- Defined: counter saturates instead of wrapping.
  - Up at MOD-1 holds MOD-1 (t_vec=0).
  - Down at 0 holds 0.
  - wrap is tied to 0.
  - tc semantics unchanged.
- Undefined: modulo wrap as above.

Decomposition:
- Package t_chain_pkg:
  - constant T_CHAIN_MAX_WIDTH=16.
  - typedef for direction enum (DIR_DOWN=0, DIR_UP=1).
  - function clamp_load(val, mod).
- One sub-module, t_cell: single toggle flip-flop with inputs clk, rst (sync active-high), t; output q. Instantiated WIDTH times via generate.
- Next-state/t_vec computation stays in the parent.

Test Plan (WIDTH=4, MOD=10 unless noted):
- rst=1 for 2 cycles, then en=1, up=1, 12 cycles -> q sequence 1..9,0,1,2; tc=1 only while q=9; wrap=1 exactly one cycle, the cycle after q goes 9->0.
- load=1 with load_val=7, then up=0, en=1 for 9 cycles -> q=7,6,...,0,9,8; wrap pulses once, after 0->9.
- load_val=13 with load=1 -> q=9 (clamped); same-cycle en=1 ignored.
- q=5 counting up, assert rst=1 together with load=1 (load_val=3) -> q=0 next edge, wrap=0.
- en=0 for 5 cycles at q=4 with up toggling -> q stays 4, tc=0, wrap=0.
- MOD=16: count up from 15 -> q=0, all four cells toggle on that edge. With T_CHAIN_COUNTER_SAT_EN defined (MOD=10), up from 8 for 4 cycles -> q=9,9,9,9 and wrap stays 0.
